// File: rtl/mux_31x16_pkg.sv
// -----------------------------------------------------------------------------
// mux_31x16_pkg
// Shared constants for the four-input word selector: the select-code values
// that route each operand to the output, and the default datapath width.
// -----------------------------------------------------------------------------
package mux_31x16_pkg;

    // Select codes: each code routes the operand of the same index to dout.
    localparam logic [1:0] SEL_ARG0 = 2'b00;
    localparam logic [1:0] SEL_ARG1 = 2'b01;
    localparam logic [1:0] SEL_ARG2 = 2'b10;
    localparam logic [1:0] SEL_ARG3 = 2'b11;

    // Default operand / output width.
    localparam int MUX_WIDTH = 16;

endpackage : mux_31x16_pkg

// File: rtl/mux_31x16_if.sv
// -----------------------------------------------------------------------------
// mux_31x16_if
// Operand/select bus of the word selector.
//   cntrl      : 2-bit select code
//   arg0..arg3 : WIDTH-bit operands selected by codes 00..11
//   dout       : WIDTH-bit selected operand
// Modports:
//   master : drives select and operands, observes dout (datapath / bench side)
//   slave  : receives select and operands, drives dout (the selector)
// -----------------------------------------------------------------------------
interface mux_31x16_if
    import mux_31x16_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
);
    logic [1:0]       cntrl;
    logic [WIDTH-1:0] arg0;
    logic [WIDTH-1:0] arg1;
    logic [WIDTH-1:0] arg2;
    logic [WIDTH-1:0] arg3;
    logic [WIDTH-1:0] dout;

    modport master (
        output cntrl,
        output arg0,
        output arg1,
        output arg2,
        output arg3,
        input  dout
    );

    modport slave (
        input  cntrl,
        input  arg0,
        input  arg1,
        input  arg2,
        input  arg3,
        output dout
    );
endinterface : mux_31x16_if

// File: rtl/mux_31x16_oreg.sv
// -----------------------------------------------------------------------------
// mux_31x16_oreg
// WIDTH-bit output register with asynchronous active-low clear.
//   clk   : clock, loads d on every rising edge
//   rst_n : asynchronous active-low clear of q
//   d     : next value
//   q     : registered value
// -----------------------------------------------------------------------------
module mux_31x16_oreg
    import mux_31x16_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Output register: cleared at once by rst_n, otherwise loads every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {WIDTH{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule : mux_31x16_oreg

// File: rtl/mux_31x16.sv
// -----------------------------------------------------------------------------
// mux_31x16
// Four-input word selector. cntrl picks one of arg0..arg3 and presents it on
// dout bit-exact. With OUT_REG=0 the path is purely combinational and clk /
// rst_n are ignored; with OUT_REG=1 dout is registered (1-cycle latency) and
// cleared asynchronously by rst_n.
//   clk   : clock (used only when OUT_REG=1)
//   rst_n : asynchronous active-low reset (used only when OUT_REG=1)
//   bus   : slave side of mux_31x16_if (cntrl, arg0..arg3 in, dout out)
// -----------------------------------------------------------------------------
module mux_31x16
    import mux_31x16_pkg::*;
#(
    parameter int WIDTH   = MUX_WIDTH,
    parameter int OUT_REG = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_31x16_if.slave  bus
);

    logic [WIDTH-1:0] sel_s;

    // Operand select. A select code carrying X/Z bits matches no item and
    // falls to the default, which forces an all-zero word.
    always_comb begin
        sel_s = {WIDTH{1'b0}};
        case (bus.cntrl)
            SEL_ARG0: sel_s = bus.arg0;
            SEL_ARG1: sel_s = bus.arg1;
            SEL_ARG2: sel_s = bus.arg2;
            SEL_ARG3: sel_s = bus.arg3;
            default:  sel_s = {WIDTH{1'b0}};
        endcase
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            mux_31x16_oreg #(
                .WIDTH (WIDTH)
            ) u_oreg (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (sel_s),
                .q     (bus.dout)
            );
        end else begin : g_bypass
            // Clock and reset have no role in the combinational build.
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ rst_n;
            assign bus.dout         = sel_s;
        end
    endgenerate

endmodule : mux_31x16

// File: tb/tb_mux_31x16.sv
// -----------------------------------------------------------------------------
// tb_mux_31x16
// Self-checking bench for mux_31x16. One instance in combinational mode and one
// in registered mode, each on its own bus interface. Expected words come from a
// lookup of the four operands indexed by the select code.
// -----------------------------------------------------------------------------
module tb_mux_31x16;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_fail;

    mux_31x16_if #(.WIDTH(16)) ifc ();
    mux_31x16_if #(.WIDTH(16)) ifr ();

    mux_31x16 #(.WIDTH(16), .OUT_REG(0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    mux_31x16 #(.WIDTH(16), .OUT_REG(1)) dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifr.slave)
    );

    // 20 ns clock period.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference: pick the operand whose position equals the select code.
    function automatic logic [15:0] ref_sel(input logic [1:0] c,
                                            input logic [15:0] a0,
                                            input logic [15:0] a1,
                                            input logic [15:0] a2,
                                            input logic [15:0] a3);
        logic [15:0] ops [4];
        ops[0] = a0;
        ops[1] = a1;
        ops[2] = a2;
        ops[3] = a3;
        if ($isunknown(c)) return 16'h0000;
        return ops[int'(c)];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_c(input logic [1:0] c, input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3);
        ifc.cntrl = c;
        ifc.arg0  = a0;
        ifc.arg1  = a1;
        ifc.arg2  = a2;
        ifc.arg3  = a3;
    endtask

    task automatic drive_r(input logic [1:0] c, input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3);
        ifr.cntrl = c;
        ifr.arg0  = a0;
        ifr.arg1  = a1;
        ifr.arg2  = a2;
        ifr.arg3  = a3;
    endtask

    initial begin
        logic [15:0] iv;
        logic [15:0] a0, a1, a2, a3, exp_prev, exp_new;
        logic [1:0]  c;
        logic [1:0]  xsel;

        n_cmp  = 0;
        n_fail = 0;

        // ---- reset state ------------------------------------------------------
        rst_n = 1'b0;
        drive_r(2'b01, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        drive_c(2'b11, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        #1;
        check("reg_reset_initial", ifr.dout, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("reg_reset_held", ifr.dout, 16'h0000);
        check("comb_ignores_reset", ifc.dout, 16'h4444);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reg_release_no_edge", ifr.dout, 16'h0000);
        @(posedge clk);
        #1;
        check("reg_first_load", ifr.dout, 16'h2222);

        // ---- exhaustive sweep, combinational --------------------------------
        for (int i = 0; i < 65536; i++) begin
            iv = i[15:0];
            a0 = iv >> 4;
            a1 = iv;
            a2 = {iv[7:0], 8'h00};
            a3 = 16'h0000;
            drive_c(iv[1:0], a0, a1, a2, a3);
            #10;
            check("sweep", ifc.dout, ref_sel(iv[1:0], a0, a1, a2, a3));
        end

        // ---- spot check at 0x1234 -------------------------------------------
        drive_c(2'b00, 16'h0123, 16'h1234, 16'h3400, 16'h0000);
        #10 check("spot_sel0", ifc.dout, 16'h0123);
        ifc.cntrl = 2'b01;
        #10 check("spot_sel1", ifc.dout, 16'h1234);
        ifc.cntrl = 2'b10;
        #10 check("spot_sel2", ifc.dout, 16'h3400);
        ifc.cntrl = 2'b11;
        #10 check("spot_sel3", ifc.dout, 16'h0000);

        // ---- isolation of unselected operands -------------------------------
        drive_c(2'b10, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            ifc.arg0 = k[0] ? 16'hFFFF : 16'h0000;
            ifc.arg1 = k[1] ? 16'hFFFF : 16'h0000;
            ifc.arg3 = k[2] ? 16'hFFFF : 16'h0000;
            #10 check("isolation", ifc.dout, 16'hA5A5);
        end

        // ---- unknown select -------------------------------------------------
        xsel = 2'bx1;
        drive_c(xsel, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        #10 check("unknown_sel", ifc.dout, ref_sel(xsel, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));

        // ---- random, combinational: select and operands change together ------
        for (int k = 0; k < 300; k++) begin
            c  = 2'($urandom_range(0, 3));
            a0 = 16'($urandom);
            a1 = 16'($urandom);
            a2 = 16'($urandom);
            a3 = 16'($urandom);
            drive_c(c, a0, a1, a2, a3);
            #10 check("rand_comb", ifc.dout, ref_sel(c, a0, a1, a2, a3));
        end

        // ---- registered latency ---------------------------------------------
        @(negedge clk);
        drive_r(2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        drive_r(2'b01, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000);
        #1 check("reg_before_edge", ifr.dout, 16'h0000);
        @(posedge clk);
        #1 check("reg_after_edge", ifr.dout, 16'hBEEF);

        // ---- registered asynchronous reset ----------------------------------
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reg_async_clear", ifr.dout, 16'h0000);
        repeat (2) @(posedge clk);
        #1 check("reg_clear_held", ifr.dout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reg_release_wait", ifr.dout, 16'h0000);
        @(posedge clk);
        #1 check("reg_reload", ifr.dout, 16'hBEEF);

        // ---- random, registered: one-cycle delayed model --------------------
        exp_prev = 16'hBEEF;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            c  = 2'($urandom_range(0, 3));
            a0 = 16'($urandom);
            a1 = 16'($urandom);
            a2 = 16'($urandom);
            a3 = 16'($urandom);
            drive_r(c, a0, a1, a2, a3);
            exp_new = ref_sel(c, a0, a1, a2, a3);
            #1 check("rand_reg_hold", ifr.dout, exp_prev);
            @(posedge clk);
            #1 check("rand_reg_load", ifr.dout, exp_new);
            exp_prev = exp_new;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mux_31x16

// File: doc/mux_31x16.md
# mux_31x16

Four-input, 16-bit-wide word selector. A 2-bit control code routes one of four operand buses to a single output bus. It sits in the datapath where an operand source must be chosen, for example ALU operand or writeback selection. The default build is purely combinational; an optional output register stage uses the block's single clock and reset.

## Interface

Parameters:
- `WIDTH`, default 16: width of each operand and of `dout`.
- `OUT_REG`, default 0: 0 gives a combinational output; 1 gives a registered output.

Ports:
- `clk`  input  1: the block's one clock. Used only when `OUT_REG=1`.
- `rst_n`  input  1: asynchronous, active-low reset. Used only when `OUT_REG=1`.
- `cntrl`  input  2: select code.
- `arg0`  input  WIDTH: operand, selected by code 00.
- `arg1`  input  WIDTH: operand, selected by code 01.
- `arg2`  input  WIDTH: operand, selected by code 10.
- `arg3`  input  WIDTH: operand, selected by code 11.
- `dout`  output  WIDTH: the selected operand.

## Operation

- Selection:
  - `cntrl`=00 → `dout`=`arg0`
  - `cntrl`=01 → `dout`=`arg1`
  - `cntrl`=10 → `dout`=`arg2`
  - `cntrl`=11 → `dout`=`arg3`
- Data passes bit-exact: no sign extension, truncation or arithmetic.
- Unknown or high-impedance bits on `cntrl` (simulation only) force `dout` to all-zeros. This is the default branch of the select.
- All four encodings are legal. No code is reserved.
- Unselected operands have no effect on `dout`. Bits of an operand that the driver leaves unchanged pass through as-is.

## Timing

`OUT_REG=0`:
- `dout` is a pure function of `cntrl` and `arg0`–`arg3`.
- Zero-cycle latency. `dout` is valid within the combinational path delay, and the bench samples 10 ns after an input change.
- `clk` and `rst_n` are ignored. Reset has no effect on `dout`.

`OUT_REG=1`:
- `dout` is loaded on every rising edge of `clk` with the value selected at that edge.
- Latency is 1 cycle. There is no enable and no handshake.
- `rst_n` low clears `dout` to 0 immediately, asynchronously, without waiting for a clock edge.
- Release of `rst_n` is sampled synchronously. The first load is on the first rising edge with `rst_n` high.
- Reset asserted mid-stream discards the pending value. `dout` stays 0 while `rst_n` is low.

Both modes:
- A `cntrl` change and operand changes happening at the same time resolve to the new operand on the new selection.
- No internal state exists other than the optional output register.

## Structure

- Shared package `mux_31x16_pkg`:
  - select-code constants `SEL_ARG0`=2'b00, `SEL_ARG1`=2'b01, `SEL_ARG2`=2'b10, `SEL_ARG3`=2'b11
  - default width constant `MUX_WIDTH`=16
- Top `mux_31x16` holds the combinational case-select.
- One sub-module, `mux_31x16_oreg`: a WIDTH-bit register with asynchronous active-low clear. It is instantiated under a generate when `OUT_REG=1`; otherwise a wire bypass is used.

## Test plan

1. Exhaustive sweep with `OUT_REG=0`. For i = 0 … 65535, drive:
   - `cntrl`=i[1:0], `arg0`=i>>4, `arg1`=i, `arg2[15:8]`=i[7:0], `arg3`=0
   - check `dout` against the selected operand 10 ns later. Zero mismatches are required.
2. Spot check at i=0x1234: `cntrl`=00, `arg0`=0x0123, `arg1`=0x1234, `arg2`=0x3400, `arg3`=0x0000 → `dout`=0x0123. Then change only `cntrl` to 01/10/11 → `dout`=0x1234, 0x3400, 0x0000 respectively.
3. Isolation: `cntrl`=10, `arg2`=0xA5A5, toggle `arg0`/`arg1`/`arg3` among 0xFFFF and 0x0000 → `dout` stays 0xA5A5 throughout.
4. Unknown select: `cntrl`=2'bx1 with all operands at 0xFFFF → `dout`=0x0000.
5. `OUT_REG=1` latency: hold `rst_n`=1, set `cntrl`=01 and `arg1`=0xBEEF before edge N → `dout`=0xBEEF after edge N, not before.
6. `OUT_REG=1` reset:
   - with `dout`=0xBEEF, assert `rst_n`=0 between edges → `dout`=0x0000 at once and stays 0 across edges
   - deassert → `dout` reloads with the selected operand on the next edge.
